// File: rtl/regs_ctrl.sv
// Front-end controller for the 2R/1W register memory: power-up init, core/debug
// arbitration and read-after-write bypass on both read ports.
module regs_ctrl #(
  parameter int REG_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [REG_WIDTH-1:0] UNITY_VAL = REG_WIDTH'(8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] core_rd_addr1,
  input  logic [ADDR_WIDTH-1:0] core_rd_addr2,
  input  logic [ADDR_WIDTH-1:0] core_wr_addr,
  input  logic                  core_we,
  input  logic [REG_WIDTH-1:0]  core_d,
  output logic [REG_WIDTH-1:0]  core_q1,
  output logic [REG_WIDTH-1:0]  core_q2,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [REG_WIDTH-1:0]  dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [REG_WIDTH-1:0]  dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr1,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr2,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  mem_d,
  input  logic [REG_WIDTH-1:0]  mem_q1,
  input  logic [REG_WIDTH-1:0]  mem_q2,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_initCnt;
  logic                    r_initDone;
  logic                    r_lockout;
  logic                    r_rvalid;
  logic                    r_hit1;
  logic                    r_hit2;
  logic [REG_WIDTH-1:0]    r_wdata;
  logic                    r_qValid;
  logic [REG_WIDTH-1:0]    r_dbgHold;

  logic                    w_init;
  logic                    w_gnt;
  logic                    w_memWe;
  logic [ADDR_WIDTH-1:0]   w_memWrAddr;
  logic [ADDR_WIDTH-1:0]   w_memRdAddr1;
  logic [ADDR_WIDTH-1:0]   w_memRdAddr2;
  logic [REG_WIDTH-1:0]    w_memD;
  logic [REG_WIDTH-1:0]    w_q1;
  logic [REG_WIDTH-1:0]    w_q2;

  // Lockout after every grant guarantees the core at least every other cycle.
  assign w_init       = (r_state == ST_INIT);
  assign w_gnt        = !w_init && dbg_req && !r_lockout;
  assign w_memWe      = w_init || (w_gnt ? dbg_we : core_we);
  assign w_memWrAddr  = w_init ? r_initCnt : (w_gnt ? dbg_addr : core_wr_addr);
  assign w_memD       = w_init ? ((r_initCnt == '0) ? '0 : UNITY_VAL)
                               : (w_gnt ? dbg_wdata : core_d);
  assign w_memRdAddr1 = w_gnt ? dbg_addr : core_rd_addr1;
  assign w_memRdAddr2 = core_rd_addr2;

  // The memory has no internal bypass, so a same-cycle write is forwarded here.
  assign w_q1 = r_hit1 ? r_wdata : mem_q1;
  assign w_q2 = r_hit2 ? r_wdata : mem_q2;

  assign mem_we       = w_memWe;
  assign mem_wr_addr  = w_memWrAddr;
  assign mem_d        = w_memD;
  assign mem_rd_addr1 = w_memRdAddr1;
  assign mem_rd_addr2 = w_memRdAddr2;

  assign dbg_gnt    = w_gnt;
  assign core_stall = w_init || w_gnt;
  assign init_done  = r_initDone;
  assign core_q1    = r_qValid ? w_q1 : '0;
  assign core_q2    = r_qValid ? w_q2 : '0;
  // A reset arriving right after a read grant drops the pending read response.
  assign dbg_rvalid = r_rvalid && !reset;
  assign dbg_rdata  = dbg_rvalid ? w_q1 : r_dbgHold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_initCnt  <= '0;
      r_initDone <= 1'b0;
      r_lockout  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_hit1     <= 1'b0;
      r_hit2     <= 1'b0;
      r_wdata    <= '0;
      r_qValid   <= 1'b0;
      r_dbgHold  <= '0;
    end else begin
      r_hit1    <= w_memWe && (w_memWrAddr == w_memRdAddr1);
      r_hit2    <= w_memWe && (w_memWrAddr == w_memRdAddr2);
      r_wdata   <= w_memD;
      r_qValid  <= 1'b1;
      r_lockout <= w_gnt;
      r_rvalid  <= w_gnt && !dbg_we;
      if (r_rvalid) begin
        r_dbgHold <= w_q1;
      end
      if (r_state == ST_INIT) begin
        r_initCnt <= r_initCnt + 1'b1;
        if (r_initCnt == LAST_ADDR) begin
          r_state    <= ST_RUN;
          r_initDone <= 1'b1;
        end
      end
    end
  end

endmodule
